shared_data_memory: RTL and testbench

- Single-clock, 256 x 16-bit data memory shared by a host/file loader port and four processor cores.
- Five independent synchronous read ports and five write ports, all usable in the same cycle.
- The host port preloads operands (matrix dimensions, then matrix data) and reads results back after processing.
- Cores 0-3 each read and write their own address/data lanes during matrix multiplication.

---
 rtl/shared_data_memory.sv | 126 ++++++++++++
 tb/tb_shared_data_memory.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_data_memory.sv
// -----------------------------------------------------------------------------
// shared_data_memory
//
// Single-clock 256 x 16-bit data memory shared by a host/file loader port and
// four processor cores. Each of the five ports has its own address, write
// enable and write data, plus a registered read-data output; all five ports
// may read and write in the same cycle.
//
// Ports:
//   clock                 system clock, all state changes on the rising edge
//   rst_n                 asynchronous active-low reset; clears every word and
//                         every read register
//   write_en_file         host write enable
//   addr_file             host read/write address
//   data_file             host write data
//   dataout_file          host read data (1-cycle latency)
//   write_en0..3          core n write enable
//   addr0..3              core n read/write address
//   datain0..3            core n write data
//   dataout0..3           core n read data (1-cycle latency)
//
// Behaviour notes:
//   - Every port registers mem[addr] on every edge, independent of its write
//     enable. Reads see the pre-edge contents (read-before-write).
//   - Same-address write collisions resolve by fixed priority:
//     file > core0 > core1 > core2 > core3.
//   - DEPTH is expected to equal 2**ADDR_WIDTH, so every address is valid.
// -----------------------------------------------------------------------------
module shared_data_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clock,
    input  logic                  rst_n,

    input  logic                  write_en_file,
    input  logic [ADDR_WIDTH-1:0] addr_file,
    input  logic [DATA_WIDTH-1:0] data_file,
    output logic [DATA_WIDTH-1:0] dataout_file,

    input  logic                  write_en0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] datain0,
    output logic [DATA_WIDTH-1:0] dataout0,

    input  logic                  write_en1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] datain1,
    output logic [DATA_WIDTH-1:0] dataout1,

    input  logic                  write_en2,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] datain2,
    output logic [DATA_WIDTH-1:0] dataout2,

    input  logic                  write_en3,
    input  logic [ADDR_WIDTH-1:0] addr3,
    input  logic [DATA_WIDTH-1:0] datain3,
    output logic [DATA_WIDTH-1:0] dataout3
);

    localparam int NUM_PORTS = 5;

    // Port index 0 is the host; indices 1..4 are cores 0..3. Lower index means
    // higher write priority.
    logic                  port_we    [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] port_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_wdata [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_rdata [NUM_PORTS];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign port_we[0]    = write_en_file;
    assign port_addr[0]  = addr_file;
    assign port_wdata[0] = data_file;

    assign port_we[1]    = write_en0;
    assign port_addr[1]  = addr0;
    assign port_wdata[1] = datain0;

    assign port_we[2]    = write_en1;
    assign port_addr[2]  = addr1;
    assign port_wdata[2] = datain1;

    assign port_we[3]    = write_en2;
    assign port_addr[3]  = addr2;
    assign port_wdata[3] = datain2;

    assign port_we[4]    = write_en3;
    assign port_addr[4]  = addr3;
    assign port_wdata[4] = datain3;

    assign dataout_file = port_rdata[0];
    assign dataout0     = port_rdata[1];
    assign dataout1     = port_rdata[2];
    assign dataout2     = port_rdata[3];
    assign dataout3     = port_rdata[4];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array must clear asynchronously to a known zero state,
            // so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                port_rdata[p] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every read below sample the
            // pre-edge array, which is exactly read-before-write.
            for (int p = 0; p < NUM_PORTS; p++) begin
                port_rdata[p] <= mem[port_addr[p]];
            end
            // Lowest priority is applied first; a later assignment to the same
            // word in this block overrides it, so the host write wins.
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                if (port_we[p]) begin
                    mem[port_addr[p]] <= port_wdata[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_shared_data_memory.sv
// -----------------------------------------------------------------------------
// tb_shared_data_memory
//
// Directed testbench for shared_data_memory: host load/readback, parallel core
// traffic, write-collision priority, read-during-write, asynchronous reset and
// boundary addresses.
// -----------------------------------------------------------------------------
module tb_shared_data_memory;

    logic        clock;
    logic        rst_n;
    logic        write_en_file;
    logic [7:0]  addr_file;
    logic [15:0] data_file;
    logic [15:0] dataout_file;
    logic        write_en0, write_en1, write_en2, write_en3;
    logic [7:0]  addr0, addr1, addr2, addr3;
    logic [15:0] datain0, datain1, datain2, datain3;
    logic [15:0] dataout0, dataout1, dataout2, dataout3;

    int n_checks = 0;
    int n_fail   = 0;

    shared_data_memory #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .DEPTH      (256)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .write_en_file (write_en_file),
        .addr_file     (addr_file),
        .data_file     (data_file),
        .dataout_file  (dataout_file),
        .write_en0     (write_en0),
        .addr0         (addr0),
        .datain0       (datain0),
        .dataout0      (dataout0),
        .write_en1     (write_en1),
        .addr1         (addr1),
        .datain1       (datain1),
        .dataout1      (dataout1),
        .write_en2     (write_en2),
        .addr2         (addr2),
        .datain2       (datain2),
        .dataout2      (dataout2),
        .write_en3     (write_en3),
        .addr3         (addr3),
        .datain3       (datain3),
        .dataout3      (dataout3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        write_en_file = 1'b0;
        write_en0 = 1'b0;
        write_en1 = 1'b0;
        write_en2 = 1'b0;
        write_en3 = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] outs [5];
        idle();
        addr_file = 8'h00; addr0 = 8'h00; addr1 = 8'h00; addr2 = 8'h00; addr3 = 8'h00;
        data_file = '0; datain0 = '0; datain1 = '0; datain2 = '0; datain3 = '0;
        rst_n = 1'b0;
        #3;
        outs = '{dataout_file, dataout0, dataout1, dataout2, dataout3};
        for (int p = 0; p < 5; p++) begin
            n_checks++;
            if (outs[p] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_out%0d got %h want 0000", p, outs[p]);
            end
        end
        @(negedge clock);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_host_load();
        logic [15:0] dims [3];
        dims = '{16'd3, 16'd2, 16'd4};
        for (int i = 0; i < 3; i++) begin
            write_en_file = 1'b1;
            addr_file = 8'(i);
            data_file = dims[i];
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            addr_file = 8'(i);
            tick();
            n_checks++;
            if (dataout_file !== dims[i]) begin
                n_fail++;
                $display("FAIL host_read%0d got %h want %h", i, dataout_file, dims[i]);
            end
        end
    endtask

    task automatic test_parallel();
        logic [15:0] outs [4];
        logic [15:0] exp  [4];
        write_en0 = 1'b1; addr0 = 8'h10; datain0 = 16'h1111;
        write_en1 = 1'b1; addr1 = 8'h11; datain1 = 16'h2222;
        write_en2 = 1'b1; addr2 = 8'h12; datain2 = 16'h3333;
        write_en3 = 1'b1; addr3 = 8'h13; datain3 = 16'h4444;
        tick();
        idle();
        addr0 = 8'h11; addr1 = 8'h12; addr2 = 8'h13; addr3 = 8'h10;
        tick();
        outs = '{dataout0, dataout1, dataout2, dataout3};
        exp  = '{16'h2222, 16'h3333, 16'h4444, 16'h1111};
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (outs[c] !== exp[c]) begin
                n_fail++;
                $display("FAIL parallel_core%0d got %h want %h", c, outs[c], exp[c]);
            end
        end
    endtask

    task automatic test_collision();
        // file + core0 + core3
        write_en_file = 1'b1; addr_file = 8'h20; data_file = 16'hAAAA;
        write_en0 = 1'b1; addr0 = 8'h20; datain0 = 16'hBBBB;
        write_en3 = 1'b1; addr3 = 8'h20; datain3 = 16'hCCCC;
        tick();
        idle();
        addr_file = 8'h20;
        tick();
        n_checks++;
        if (dataout_file !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL collide_file got %h want AAAA", dataout_file);
        end
        // core0 + core3
        write_en0 = 1'b1; write_en3 = 1'b1;
        tick();
        idle();
        tick();
        n_checks++;
        if (dataout_file !== 16'hBBBB) begin
            n_fail++;
            $display("FAIL collide_core0 got %h want BBBB", dataout_file);
        end
        // core1 + core2 + core3 at 0x21
        write_en1 = 1'b1; addr1 = 8'h21; datain1 = 16'h1010;
        write_en2 = 1'b1; addr2 = 8'h21; datain2 = 16'h2020;
        write_en3 = 1'b1; addr3 = 8'h21; datain3 = 16'h3030;
        tick();
        idle();
        addr_file = 8'h21;
        tick();
        n_checks++;
        if (dataout_file !== 16'h1010) begin
            n_fail++;
            $display("FAIL collide_core1 got %h want 1010", dataout_file);
        end
        // core2 + core3 at 0x21
        write_en2 = 1'b1; write_en3 = 1'b1;
        tick();
        idle();
        tick();
        n_checks++;
        if (dataout_file !== 16'h2020) begin
            n_fail++;
            $display("FAIL collide_core2 got %h want 2020", dataout_file);
        end
    endtask

    task automatic test_read_during_write();
        write_en_file = 1'b1; addr_file = 8'h30; data_file = 16'h0005;
        tick();
        idle();
        write_en1 = 1'b1; addr1 = 8'h30; datain1 = 16'h0009;
        addr2 = 8'h30;
        tick();
        idle();
        n_checks++;
        if (dataout2 !== 16'h0005) begin
            n_fail++;
            $display("FAIL rdw_old_core2 got %h want 0005", dataout2);
        end
        n_checks++;
        if (dataout1 !== 16'h0005) begin
            n_fail++;
            $display("FAIL rdw_old_core1 got %h want 0005", dataout1);
        end
        tick();
        n_checks++;
        if (dataout2 !== 16'h0009) begin
            n_fail++;
            $display("FAIL rdw_new_core2 got %h want 0009", dataout2);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] outs [5];
        write_en_file = 1'b1; addr_file = 8'hFF; data_file = 16'h7FFF;
        tick();
        idle();
        addr0 = 8'hFF; addr1 = 8'hFF; addr2 = 8'hFF; addr3 = 8'hFF;
        tick();
        n_checks++;
        if (dataout_file !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL preload_ff got %h want 7FFF", dataout_file);
        end
        // Pulse reset between edges and check outputs before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        outs = '{dataout_file, dataout0, dataout1, dataout2, dataout3};
        for (int p = 0; p < 5; p++) begin
            n_checks++;
            if (outs[p] !== 16'h0000) begin
                n_fail++;
                $display("FAIL async_rst_out%0d got %h want 0000", p, outs[p]);
            end
        end
        // Hold reset across an edge with a write pending; it must be lost.
        write_en0 = 1'b1; addr0 = 8'h40; datain0 = 16'h5555;
        tick();
        n_checks++;
        if (dataout_file !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_hold_out got %h want 0000", dataout_file);
        end
        @(negedge clock);
        idle();
        rst_n = 1'b1;
        addr_file = 8'hFF; addr0 = 8'h40;
        tick();
        n_checks++;
        if (dataout_file !== 16'h0000) begin
            n_fail++;
            $display("FAIL post_rst_ff got %h want 0000", dataout_file);
        end
        n_checks++;
        if (dataout0 !== 16'h0000) begin
            n_fail++;
            $display("FAIL post_rst_pending got %h want 0000", dataout0);
        end
    endtask

    task automatic test_boundary();
        write_en_file = 1'b1; addr_file = 8'h00; data_file = 16'hFFFF;
        write_en3 = 1'b1; addr3 = 8'hFF; datain3 = 16'h1234;
        tick();
        idle();
        tick();
        n_checks++;
        if (dataout_file !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL bnd_file_00 got %h want FFFF", dataout_file);
        end
        n_checks++;
        if (dataout3 !== 16'h1234) begin
            n_fail++;
            $display("FAIL bnd_core3_ff got %h want 1234", dataout3);
        end
        addr_file = 8'hFF; addr3 = 8'h00;
        tick();
        n_checks++;
        if (dataout_file !== 16'h1234) begin
            n_fail++;
            $display("FAIL bnd_file_ff got %h want 1234", dataout_file);
        end
        n_checks++;
        if (dataout3 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL bnd_core3_00 got %h want FFFF", dataout3);
        end
        // Outputs hold between edges.
        #4;
        n_checks++;
        if (dataout3 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL bnd_hold got %h want FFFF", dataout3);
        end
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_parallel();
        test_collision();
        test_read_during_write();
        test_async_reset();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
